audio_dac_serializer: RTL and testbench

Parametrised stereo DAC serializer. Sits between the sample source (SDRAM read path or tone generator) and the codec's DAC data pin, all in the `clock_50M` domain. Oversamples the codec-mastered `bclk` and `dacclk` (LR clock) and buffers frames in a small FIFO with a valid/ready handshake. Shifts out left-justified or I2S-format frames with configurable sample and slot width, mute, and underrun detection.

---
 rtl/audio_pkg.sv | 17 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/audio_dac_serializer.sv | 136 +++++++++++++
 tb/tb_audio_dac_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the stereo DAC serializer.
// Slots are limited to MAX_SLOT_W bits so the packing helper can use a fixed width.
package audio_pkg;

  localparam logic FMT_LJ  = 1'b0;
  localparam logic FMT_I2S = 1'b1;

  localparam int MAX_SLOT_W = 64;

  typedef logic [MAX_SLOT_W-1:0] slot_t;

  // Moves a right-aligned sample up so its MSB lands on bit slot_w-1, zero-filling below.
  function automatic slot_t pack_slot(input slot_t sample, input int sample_w, input int slot_w);
    return sample << (slot_w - sample_w);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output; a simultaneous push and pop leaves the level unchanged.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// Stereo DAC serializer: oversamples codec bclk/LR clock, buffers frames in a FIFO and
// shifts them out left-justified or I2S, with mute and underrun reporting.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter bit LR_POL     = 1'b1
) (
  input  logic                          clock_50M,
  input  logic                          reset,
  input  logic                          bclk,
  input  logic                          dacclk,
  input  logic                          fmt_i2s,
  input  logic                          mute,
  input  logic [2*SAMPLE_W-1:0]         sample_data,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          dacdat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_cnt
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  logic [2:0]              bclk_sync_q, bclk_sync_d;
  logic [2:0]              lr_sync_q, lr_sync_d;
  logic                    frame_start, bclk_fall;

  logic [2*SAMPLE_W-1:0]   fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic                    fifo_push, fifo_pop;

  logic [SLOT_W-1:0]       left_slot, right_slot;
  logic [FRAME_W-1:0]      frame;

  logic [FRAME_W-1:0]      shreg_q, shreg_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    dacdat_q, dacdat_d;
  logic                    underrun_q, underrun_d;
  logic [15:0]             underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    bclk_sync_d = {bclk_sync_q[1:0], bclk};
    lr_sync_d   = {lr_sync_q[1:0], dacclk};
  end

  // Bit 1 is the settled sample (s2), bit 2 the one before it (s3).
  assign bclk_fall   = !bclk_sync_q[1] && bclk_sync_q[2];
  assign frame_start = LR_POL ? ( lr_sync_q[1] && !lr_sync_q[2])
                              : (!lr_sync_q[1] &&  lr_sync_q[2]);

  assign sample_ready = !fifo_full;
  assign fifo_push    = sample_valid && sample_ready;
  assign fifo_pop     = frame_start && !fifo_empty;

  sync_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock_50M),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (sample_data),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    left_slot  = SLOT_W'(pack_slot(slot_t'(fifo_rdata[2*SAMPLE_W-1 -: SAMPLE_W]), SAMPLE_W, SLOT_W));
    right_slot = SLOT_W'(pack_slot(slot_t'(fifo_rdata[SAMPLE_W-1:0]), SAMPLE_W, SLOT_W));
    frame      = (mute || fifo_empty) ? '0 : {left_slot, right_slot};
  end

  // A frame start takes priority and swallows any bclk fall seen in the same cycle.
  always_comb begin
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    dacdat_d       = dacdat_q;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    if (frame_start) begin
      bit_cnt_d = '0;
      if (fmt_i2s == FMT_I2S) begin
        dacdat_d = shreg_q[FRAME_W-1];
        shreg_d  = frame;
      end else begin
        dacdat_d = frame[FRAME_W-1];
        shreg_d  = frame << 1;
      end
      if (fifo_empty) begin
        underrun_d = 1'b1;
        if (underrun_cnt_q != 16'hFFFF) begin
          underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
      end
    end else if (bclk_fall) begin
      dacdat_d = shreg_q[FRAME_W-1];
      shreg_d  = shreg_q << 1;
      if (bit_cnt_q != CNT_W'(FRAME_W)) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_50M) begin
    if (reset) begin
      bclk_sync_q    <= '0;
      lr_sync_q      <= '0;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      dacdat_q       <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      bclk_sync_q    <= bclk_sync_d;
      lr_sync_q      <= lr_sync_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      dacdat_q       <= dacdat_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign dacdat       = dacdat_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Randomized self-checking bench for audio_dac_serializer (default parameters, LR_POL=1).
// A queue-based model predicts the serial stream, FIFO level and underrun reporting.
module tb_audio_dac_serializer;

  logic        clock_50M = 1'b0;
  logic        reset = 1'b1;
  logic        bclk = 1'b1;
  logic        dacclk = 1'b0;
  logic        fmt_i2s = 1'b0;
  logic        mute = 1'b0;
  logic [31:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        dacdat;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic [15:0] underrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_q [$];
  logic        prev_bit;
  int          model_under_cnt;

  audio_dac_serializer #(
    .SAMPLE_W   (16),
    .SLOT_W     (32),
    .FIFO_DEPTH (4),
    .LR_POL     (1'b1)
  ) dut (
    .clock_50M    (clock_50M),
    .reset        (reset),
    .bclk         (bclk),
    .dacclk       (dacclk),
    .fmt_i2s      (fmt_i2s),
    .mute         (mute),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dacdat       (dacdat),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #10 clock_50M = ~clock_50M;

  function automatic logic [63:0] expect_frame(input logic [31:0] d);
    return {d[31:16], 16'h0000, d[15:0], 16'h0000};
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    bclk         = 1'b1;
    dacclk       = 1'b0;
    sample_valid = 1'b0;
    repeat (4) @(negedge clock_50M);
    reset = 1'b0;
    repeat (4) @(negedge clock_50M);
    model_q.delete();
    prev_bit        = 1'b0;
    model_under_cnt = 0;
  endtask

  task automatic push_frame(input logic [31:0] d);
    logic exp_ready;
    exp_ready    = (model_q.size() < 4);
    sample_data  = d;
    sample_valid = 1'b1;
    n_checks++;
    if (sample_ready !== exp_ready) begin
      n_fail++;
      $display("[TB] FAIL push_ready: got %b expected %b", sample_ready, exp_ready);
    end
    @(negedge clock_50M);
    sample_valid = 1'b0;
    if (exp_ready) model_q.push_back(d);
    n_checks++;
    if (fifo_level !== 3'(model_q.size())) begin
      n_fail++;
      $display("[TB] FAIL push_level: got %0d expected %0d", fifo_level, model_q.size());
    end
  endtask

  // Plays one 64-bclk frame starting on a dacclk rise; stops early (bclk high) at stop_bit.
  task automatic run_frame(input logic fmt, input logic mte, input int stop_bit, input int level_adj);
    logic [63:0] frame;
    logic [31:0] d;
    logic        exp_under;
    logic        exp_bit;
    int          under_seen;
    fmt_i2s    = fmt;
    mute       = mte;
    exp_under  = (model_q.size() == 0);
    frame      = '0;
    if (!exp_under) begin
      d = model_q.pop_front();
      if (!mte) frame = expect_frame(d);
    end else if (model_under_cnt < 16'hFFFF) begin
      model_under_cnt++;
    end
    under_seen = 0;
    for (int k = 0; k < 64; k++) begin
      if (k == stop_bit) return;
      bclk = 1'b0;
      if (k == 0)  dacclk = 1'b1;
      if (k == 32) dacclk = 1'b0;
      // I2S is the left-justified stream delayed by one bit clock.
      if (fmt) exp_bit = (k == 0) ? prev_bit : frame[64-k];
      else     exp_bit = frame[63-k];
      for (int c = 0; c < 8; c++) begin
        @(negedge clock_50M);
        if (underrun === 1'b1) under_seen++;
        if (c == 3) bclk = 1'b1;
      end
      n_checks++;
      if (dacdat !== exp_bit) begin
        n_fail++;
        $display("[TB] FAIL dacdat_bit%0d (fmt=%0d mute=%0d): got %b expected %b", k, fmt, mte, dacdat, exp_bit);
      end
      if (k == 1) begin
        n_checks++;
        if (fifo_level !== 3'(model_q.size() + level_adj)) begin
          n_fail++;
          $display("[TB] FAIL frame_level: got %0d expected %0d", fifo_level, model_q.size() + level_adj);
        end
      end
    end
    n_checks++;
    if (under_seen != int'(exp_under)) begin
      n_fail++;
      $display("[TB] FAIL underrun_pulses: got %0d expected %0d", under_seen, exp_under);
    end
    n_checks++;
    if (underrun_cnt !== 16'(model_under_cnt)) begin
      n_fail++;
      $display("[TB] FAIL underrun_cnt: got %0d expected %0d", underrun_cnt, model_under_cnt);
    end
    prev_bit = fmt ? frame[0] : 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dacdat !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dacdat: got %b expected 0", dacdat); end
    n_checks++;
    if (sample_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", sample_ready); end
    n_checks++;
    if (fifo_level !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
    n_checks++;
    if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
    n_checks++;
    if (underrun_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_ucnt: got %0d expected 0", underrun_cnt); end
  endtask

  task automatic test_lj_frame();
    do_reset();
    push_frame(32'hA5F0_0F0F);
    run_frame(1'b0, 1'b0, 64, 0);
    push_frame($urandom);
    push_frame($urandom);
    run_frame(1'b0, 1'b0, 64, 0);
    run_frame(1'b0, 1'b0, 64, 0);
  endtask

  task automatic test_i2s();
    do_reset();
    push_frame(32'hA5F0_0F0F);
    push_frame(32'hA5F0_0F0F);
    run_frame(1'b1, 1'b0, 64, 0);
    run_frame(1'b1, 1'b0, 64, 0);
  endtask

  task automatic test_underrun();
    do_reset();
    for (int f = 0; f < 3; f++) run_frame(1'b0, 1'b0, 64, 0);
    n_checks++;
    if (underrun_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL underrun_total: got %0d expected 3", underrun_cnt); end
  endtask

  task automatic test_fill();
    logic [31:0] held;
    do_reset();
    for (int i = 0; i < 4; i++) push_frame($urandom);
    n_checks++;
    if (sample_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready: got %b expected 0", sample_ready); end
    push_frame($urandom);
    held         = $urandom;
    sample_data  = held;
    sample_valid = 1'b1;
    run_frame(1'b0, 1'b0, 64, 1);
    sample_valid = 1'b0;
    model_q.push_back(held);
    n_checks++;
    if (fifo_level !== 3'd4) begin n_fail++; $display("[TB] FAIL refill_level: got %0d expected 4", fifo_level); end
    n_checks++;
    if (sample_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL refill_ready: got %b expected 0", sample_ready); end
    for (int i = 0; i < 4; i++) run_frame(1'b0, 1'b0, 64, 0);
    n_checks++;
    if (fifo_level !== 3'd0) begin n_fail++; $display("[TB] FAIL drain_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_mute();
    do_reset();
    push_frame($urandom);
    push_frame($urandom);
    run_frame(1'b0, 1'b1, 64, 0);
    run_frame(1'b0, 1'b0, 64, 0);
  endtask

  task automatic test_reset_mid_frame();
    int stops [2];
    stops[0] = 20;
    stops[1] = 5;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      push_frame((r == 1) ? 32'hFFFF_FFFF : $urandom);
      push_frame($urandom);
      run_frame(1'b0, 1'b0, stops[r], 0);
      reset  = 1'b1;
      dacclk = 1'b0;
      bclk   = 1'b1;
      @(negedge clock_50M);
      n_checks++;
      if (dacdat !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_dacdat: got %b expected 0", dacdat); end
      n_checks++;
      if (fifo_level !== 3'd0) begin n_fail++; $display("[TB] FAIL midreset_level: got %0d expected 0", fifo_level); end
      repeat (3) @(negedge clock_50M);
      reset = 1'b0;
      repeat (4) @(negedge clock_50M);
      model_q.delete();
      prev_bit        = 1'b0;
      model_under_cnt = 0;
      push_frame($urandom);
      run_frame(1'b0, 1'b0, 64, 0);
    end
  endtask

  task automatic test_random();
    int n_push;
    for (int f = 0; f < 8; f++) begin
      n_push = $urandom_range(0, 2);
      for (int p = 0; p < n_push; p++) begin
        if (model_q.size() < 4) push_frame($urandom);
      end
      run_frame(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 64, 0);
    end
  endtask

  initial begin
    test_reset();
    test_lj_frame();
    test_i2s();
    test_underrun();
    test_fill();
    test_mute();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
